// File: rtl/serv_bufreg_seq.sv
// Sequencer for the bit-serial buffer register: init pass, data-bus wait, shift pass, run pass.
// Latency: plain op 32 en cycles, done at start+33; shift adds 32+shamt; load/store add the bus wait.
// Backpressure: i_start is only sampled in IDLE; the bus phase stalls until i_dbus_ack or timeout.
module serv_bufreg_seq #(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned TW      = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_mem_op,
    input  logic       i_mem_wr,
    input  logic       i_sh_op,
    input  logic [4:0] i_shamt,
    input  logic       i_dbus_ack,
    output logic [4:0] o_cnt,
    output logic       o_cnt0,
    output logic       o_cnt1,
    output logic       o_en,
    output logic       o_init,
    output logic       o_dbus_cyc,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_BUS   = 3'd2,
        S_SHIFT = 3'd3,
        S_RUN   = 3'd4
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [4:0]    shcnt_q, shcnt_d;
    logic [TW-1:0] tocnt_q, tocnt_d;
    logic          mem_op_q, mem_op_d;
    logic          mem_wr_q, mem_wr_d;
    logic          sh_op_q, sh_op_d;
    logic [4:0]    shamt_q, shamt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          cnt_phase;
    logic          bus_expired;

    // Strobes decode straight from the registered state so they fall to 0 with reset.
    always_comb begin
        cnt_phase  = (state_q == S_INIT) || (state_q == S_RUN);
        o_en       = cnt_phase || (state_q == S_SHIFT);
        o_init     = (state_q == S_INIT);
        o_dbus_cyc = (state_q == S_BUS);
        o_cnt      = cnt_q;
        o_cnt0     = cnt_phase && (cnt_q == 5'd0);
        o_cnt1     = cnt_phase && (cnt_q == 5'd1);
        o_busy     = busy_q;
        o_done     = done_q;
        o_err      = err_q;
    end

    // Next-state, counters and completion pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = 5'd0;
        shcnt_d     = shcnt_q;
        tocnt_d     = '0;
        mem_op_d    = mem_op_q;
        mem_wr_d    = mem_wr_q;
        sh_op_d     = sh_op_q;
        shamt_d     = shamt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        bus_expired = TO_EN && (tocnt_q == TO_LAST);

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mem_op_d = i_mem_op;
                    mem_wr_d = i_mem_wr;
                    sh_op_d  = i_sh_op;
                    shamt_d  = i_shamt;
                    state_d  = (i_mem_op || i_sh_op) ? S_INIT : S_RUN;
                end
            end
            S_INIT: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    if (mem_op_q) begin
                        state_d = S_BUS;
                    end else if (shamt_q != 5'd0) begin
                        state_d = S_SHIFT;
                        shcnt_d = shamt_q;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_BUS: begin
                // Counter stays cleared outside BUS, so it restarts on every entry.
                if (TO_EN) tocnt_d = tocnt_q + 1'b1;
                if (i_dbus_ack) begin
                    // Ack wins over an expiry in the same cycle.
                    if (mem_wr_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (bus_expired) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_SHIFT: begin
                shcnt_d = shcnt_q - 5'd1;
                if (shcnt_q == 5'd1) state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers; reset aborts any operation without a pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            shcnt_q  <= 5'd0;
            tocnt_q  <= '0;
            mem_op_q <= 1'b0;
            mem_wr_q <= 1'b0;
            sh_op_q  <= 1'b0;
            shamt_q  <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shcnt_q  <= shcnt_d;
            tocnt_q  <= tocnt_d;
            mem_op_q <= mem_op_d;
            mem_wr_q <= mem_wr_d;
            sh_op_q  <= sh_op_d;
            shamt_q  <= shamt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_serv_bufreg_seq.sv
module tb_serv_bufreg_seq;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_mem_op = 1'b0;
    logic       i_mem_wr = 1'b0;
    logic       i_sh_op = 1'b0;
    logic [4:0] i_shamt = 5'd0;
    logic       i_dbus_ack = 1'b0;
    logic [4:0] o_cnt;
    logic       o_cnt0, o_cnt1, o_en, o_init, o_dbus_cyc, o_busy, o_done, o_err;

    serv_bufreg_seq #(.TIMEOUT(10), .TW(16)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mem_op(i_mem_op),
        .i_mem_wr(i_mem_wr), .i_sh_op(i_sh_op), .i_shamt(i_shamt), .i_dbus_ack(i_dbus_ack),
        .o_cnt(o_cnt), .o_cnt0(o_cnt0), .o_cnt1(o_cnt1), .o_en(o_en), .o_init(o_init),
        .o_dbus_cyc(o_dbus_cyc), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    // ack_at: 0 = never ack, -1 = ack held high for the whole op, n = ack in the n-th BUS cycle
    typedef struct {
        logic       mem_op;
        logic       mem_wr;
        logic       sh_op;
        logic [4:0] shamt;
        int         ack_at;
        int         exp_en;
        int         exp_init;
        int         exp_bus;
        int         exp_cnt0;
        int         exp_end;
        logic       exp_done;
    } vec_t;

    localparam int NVEC = 12;
    vec_t vecs[NVEC];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({o_cnt, o_cnt0, o_cnt1, o_en, o_init, o_dbus_cyc, o_busy, o_done, o_err});
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc, en_n, init_n, bus_n, cnt0_n, cnt1_n, busy_n, end_cyc;
        logic seen_done, seen_err;
        string tag;
        tag = $sformatf("v%0d", idx);
        en_n = 0; init_n = 0; bus_n = 0; cnt0_n = 0; cnt1_n = 0; busy_n = 0;
        end_cyc = -1; seen_done = 1'b0; seen_err = 1'b0;
        i_mem_op = v.mem_op; i_mem_wr = v.mem_wr; i_sh_op = v.sh_op; i_shamt = v.shamt;
        i_dbus_ack = (v.ack_at == -1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0; i_mem_op = 1'b0; i_mem_wr = 1'b0; i_sh_op = 1'b0; i_shamt = 5'd0;
        for (cyc = 1; cyc < 400; cyc++) begin
            if (o_done || o_err) begin
                end_cyc = cyc; seen_done = o_done; seen_err = o_err;
                break;
            end
            en_n   += int'(o_en);
            init_n += int'(o_init);
            cnt0_n += int'(o_cnt0);
            cnt1_n += int'(o_cnt1);
            busy_n += int'(o_busy);
            if (o_dbus_cyc) begin
                bus_n++;
                i_dbus_ack = (v.ack_at == bus_n) || (v.ack_at == -1);
            end else begin
                i_dbus_ack = (v.ack_at == -1);
            end
            tick();
        end
        i_dbus_ack = 1'b0;
        check({tag, "_end_cycle"}, end_cyc, v.exp_end);
        check({tag, "_done"}, int'(seen_done), int'(v.exp_done));
        check({tag, "_err"}, int'(seen_err), int'(!v.exp_done));
        check({tag, "_en_cycles"}, en_n, v.exp_en);
        check({tag, "_init_cycles"}, init_n, v.exp_init);
        check({tag, "_bus_cycles"}, bus_n, v.exp_bus);
        check({tag, "_cnt0_pulses"}, cnt0_n, v.exp_cnt0);
        check({tag, "_cnt1_pulses"}, cnt1_n, v.exp_cnt0);
        check({tag, "_busy_cycles"}, busy_n, v.exp_end - 1);
        check({tag, "_busy_in_end"}, int'(o_busy), 0);
        tick();
        check({tag, "_pulse_width"}, int'({o_done, o_err, o_busy}), 0);
    endtask

    initial begin
        int cyc, done_cyc, init_n, stray;

        //            mem wr sh shamt ack  en  init bus c0 end done
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 5'd0,  0, 32,  0,  0, 1, 33, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 5'd5,  0, 69, 32,  0, 2, 70, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 5'd0,  0, 64, 32,  0, 2, 65, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 5'd0,  7, 64, 32,  7, 2, 72, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 5'd0,  3, 32, 32,  3, 1, 36, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 5'd0,  0, 32, 32, 10, 1, 43, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 5'd0,  0, 32, 32, 10, 1, 43, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 5'd0, 10, 32, 32, 10, 1, 43, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 5'd9,  2, 64, 32,  2, 2, 67, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 5'd0, -1, 32,  0,  0, 1, 33, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 5'd31, 0, 95, 32,  0, 2, 96, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 5'd0,  1, 64, 32,  1, 2, 66, 1'b1};

        // Reset state
        #2;
        check("reset_outputs", all_outs(), 0);
        tick();
        i_rst_n = 1'b1;
        tick();
        check("idle_after_reset", all_outs(), 0);

        for (int i = 0; i < NVEC; i++) run_vec(i, vecs[i]);

        // Asynchronous reset in the middle of RUN
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (9) tick();
        check("mid_run_cnt", int'(o_cnt), 9);
        check("mid_run_en", int'(o_en), 1);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 0);
        tick();
        i_rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 40; c++) begin
            stray += int'(o_done) + int'(o_err) + int'(o_en);
            tick();
        end
        check("no_pulse_after_abort", stray, 0);

        // i_start held through a plain op: ignored while busy, accepted in the done cycle
        i_start = 1'b1;
        tick();
        i_sh_op = 1'b1;
        i_shamt = 5'd3;
        done_cyc = -1;
        init_n = 0;
        for (cyc = 1; cyc < 200; cyc++) begin
            if (o_done) begin
                done_cyc = cyc;
                break;
            end
            init_n += int'(o_init);
            tick();
        end
        check("held_start_done_cycle", done_cyc, 33);
        check("held_start_no_init", init_n, 0);
        tick();
        i_start = 1'b0;
        i_sh_op = 1'b0;
        i_shamt = 5'd0;
        check("b2b_init", int'(o_init), 1);
        check("b2b_busy", int'(o_busy), 1);
        check("b2b_cnt", int'(o_cnt), 0);
        check("b2b_cnt0", int'(o_cnt0), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
